// File: rtl/pll_cfg_pkg.sv
// Shared types and constants for the PLL dynamic-reconfiguration controller.
// Holds the code width, FSM state enum, code bundle struct and mode presets.
package pll_cfg_pkg;

    localparam int PLL_CODE_W = 7;

    typedef logic [PLL_CODE_W-1:0] pll_code_t;

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT,
        ST_STAB,
        ST_RUN,
        ST_FAIL
    } pll_ctrl_state_t;

    typedef struct packed {
        pll_code_t mdsel;
        pll_code_t odsel0;
        pll_code_t odsel1;
        pll_code_t odsel2;
    } pll_codes_t;

    function automatic pll_codes_t pack_codes(
        input pll_code_t mdsel,
        input pll_code_t odsel0,
        input pll_code_t odsel1,
        input pll_code_t odsel2
    );
        pll_codes_t c;
        c.mdsel  = mdsel;
        c.odsel0 = odsel0;
        c.odsel1 = odsel1;
        c.odsel2 = odsel2;
        return c;
    endfunction

    // Video-rate presets handed to the controller by the mode switch.
    localparam pll_codes_t NTSC_CODES = '{
        mdsel:  7'd28,
        odsel0: 7'd26,
        odsel1: 7'd26,
        odsel2: 7'd52
    };

    localparam pll_codes_t PAL_CODES = '{
        mdsel:  7'd30,
        odsel0: 7'd24,
        odsel1: 7'd24,
        odsel2: 7'd48
    };

endpackage

// File: rtl/pll_dyn_ctrl_if.sv
// Reconfiguration request channel: valid/ready handshake plus divider codes.
// master = requester (core side), slave = pll_dyn_ctrl.
interface pll_dyn_ctrl_if;
    import pll_cfg_pkg::*;

    logic      req_valid;
    logic      req_ready;
    pll_code_t req_mdsel;
    pll_code_t req_odsel0;
    pll_code_t req_odsel1;
    pll_code_t req_odsel2;

    modport master (
        output req_valid,
        output req_mdsel,
        output req_odsel0,
        output req_odsel1,
        output req_odsel2,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_mdsel,
        input  req_odsel0,
        input  req_odsel1,
        input  req_odsel2,
        output req_ready
    );

endinterface

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing the PLL LOCK pin into the clk domain.
// Ports: clk, reset (sync, active-high), din (async), dout (synced).
module lock_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    assign dout = sync_q[1];

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL dynamic-reconfiguration initiator: loads divider codes, pulses PLL
// reset, waits for and qualifies lock, then reports clock-good to the core.
// Ports: clk, reset (sync, active-high); req (slave request channel);
//        pll_lock (async in); pll_reset, pll_mdsel, pll_odsel0..2 (to PLL);
//        clk_ok, done, lock_lost, fail (status to core).
module pll_dyn_ctrl
    import pll_cfg_pkg::*;
#(
    parameter pll_code_t DEF_MDSEL    = 7'd28,
    parameter pll_code_t DEF_ODSEL0   = 7'd26,
    parameter pll_code_t DEF_ODSEL1   = 7'd26,
    parameter pll_code_t DEF_ODSEL2   = 7'd52,
    parameter int        RST_CYCLES   = 16,
    parameter int        LOCK_TIMEOUT = 500000,
    parameter int        LOCK_STABLE  = 1024,
    parameter int        MAX_RETRY    = 3,
    parameter int        CNT_W        = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    pll_dyn_ctrl_if.slave        req,
    input  logic                 pll_lock,
    output logic                 pll_reset,
    output logic [PLL_CODE_W-1:0] pll_mdsel,
    output logic [PLL_CODE_W-1:0] pll_odsel0,
    output logic [PLL_CODE_W-1:0] pll_odsel1,
    output logic [PLL_CODE_W-1:0] pll_odsel2,
    output logic                 clk_ok,
    output logic                 done,
    output logic                 lock_lost,
    output logic                 fail
);

    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam pll_codes_t DEF_CODES =
        pack_codes(DEF_MDSEL, DEF_ODSEL0, DEF_ODSEL1, DEF_ODSEL2);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT cycle that first sees lock_s high is the first stable
    // cycle, so STAB itself only needs LOCK_STABLE-1 more.
    localparam logic [CNT_W-1:0] STB_LAST =
        CNT_W'((LOCK_STABLE > 1) ? LOCK_STABLE - 2 : 0);
    localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

    pll_ctrl_state_t  state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [RTY_W-1:0] retry;
    pll_codes_t       codes_q;
    pll_codes_t       req_codes;
    logic             rdy_q;
    logic             lock_s;
    logic             accept;

    lock_sync u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pll_lock),
        .dout  (lock_s)
    );

    assign req_codes = pack_codes(req.req_mdsel, req.req_odsel0,
                                  req.req_odsel1, req.req_odsel2);
    assign accept    = req.req_valid & rdy_q;
    assign req.req_ready = rdy_q;

    // Saturating increment: the counter never wraps.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    assign pll_mdsel  = codes_q.mdsel;
    assign pll_odsel0 = codes_q.odsel0;
    assign pll_odsel1 = codes_q.odsel1;
    assign pll_odsel2 = codes_q.odsel2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RST;
            cnt       <= '0;
            retry     <= '0;
            codes_q   <= DEF_CODES;
            pll_reset <= 1'b1;
            clk_ok    <= 1'b0;
            done      <= 1'b0;
            lock_lost <= 1'b0;
            fail      <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            done      <= 1'b0;
            lock_lost <= 1'b0;
            // Accept outranks a same-cycle lock drop in RUN.
            if (accept) begin
                state     <= ST_RST;
                cnt       <= '0;
                retry     <= '0;
                fail      <= 1'b0;
                codes_q   <= req_codes;
                pll_reset <= 1'b1;
                clk_ok    <= 1'b0;
                rdy_q     <= 1'b0;
            end else begin
                unique case (state)
                    ST_RST: begin
                        if (cnt == RST_LAST) begin
                            state     <= ST_WAIT;
                            cnt       <= '0;
                            pll_reset <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_WAIT: begin
                        if (lock_s) begin
                            state <= ST_STAB;
                            cnt   <= '0;
                        end else if (cnt == TMO_LAST) begin
                            if (retry < RTY_MAX) begin
                                retry     <= retry + 1'b1;
                                state     <= ST_RST;
                                cnt       <= '0;
                                pll_reset <= 1'b1;
                            end else begin
                                state <= ST_FAIL;
                                fail  <= 1'b1;
                                rdy_q <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_STAB: begin
                        if (!lock_s) begin
                            state <= ST_WAIT;
                            cnt   <= '0;
                        end else if (cnt == STB_LAST) begin
                            state  <= ST_RUN;
                            cnt    <= '0;
                            retry  <= '0;
                            clk_ok <= 1'b1;
                            done   <= 1'b1;
                            rdy_q  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_RUN: begin
                        if (!lock_s) begin
                            state     <= ST_WAIT;
                            cnt       <= '0;
                            clk_ok    <= 1'b0;
                            lock_lost <= 1'b1;
                            rdy_q     <= 1'b0;
                        end
                    end
                    ST_FAIL: begin
                        state <= ST_FAIL;
                    end
                    default: begin
                        state <= ST_RST;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Scoreboard bench for pll_dyn_ctrl: event timelines are predicted from
// the sequencing rules and compared against edges seen on the outputs.
module tb_pll_dyn_ctrl;
    import pll_cfg_pkg::*;

    localparam int RSTC = 4;
    localparam int TMO  = 50;
    localparam int STB  = 8;
    localparam int MRT  = 2;
    localparam int SYNC = 2;

    localparam pll_codes_t DEF_C = '{
        mdsel: 7'd28, odsel0: 7'd26, odsel1: 7'd26, odsel2: 7'd52
    };

    typedef enum int {
        EV_PUP, EV_REL, EV_CKDN, EV_DONE, EV_LOST, EV_FSET, EV_FCLR
    } ev_k_t;

    typedef struct packed {
        ev_k_t      k;
        int         at;
        pll_codes_t c;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [6:0] pll_mdsel, pll_odsel0, pll_odsel1, pll_odsel2;
    logic       clk_ok, done, lock_lost, fail;
    pll_codes_t codes_out;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    pll_dyn_ctrl_if rif();

    pll_dyn_ctrl #(
        .RST_CYCLES   (RSTC),
        .LOCK_TIMEOUT (TMO),
        .LOCK_STABLE  (STB),
        .MAX_RETRY    (MRT),
        .CNT_W        (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (rif),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_mdsel  (pll_mdsel),
        .pll_odsel0 (pll_odsel0),
        .pll_odsel1 (pll_odsel1),
        .pll_odsel2 (pll_odsel2),
        .clk_ok     (clk_ok),
        .done       (done),
        .lock_lost  (lock_lost),
        .fail       (fail)
    );

    assign codes_out = {pll_mdsel, pll_odsel0, pll_odsel1, pll_odsel2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)",
                     nm, act, exp_v, cyc);
        end
    endtask

    task automatic push(ev_k_t k, int at, pll_codes_t c = '0);
        ev_t e;
        e.k  = k;
        e.at = at;
        e.c  = c;
        exp_q.push_back(e);
    endtask

    task automatic got(ev_k_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got %s want none (cyc %0d)",
                     k.name(), cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 32'(k), 32'(e.k));
        chk($sformatf("%s_cycle", k.name()), 32'(cyc), 32'(e.at));
        if (k == EV_REL) chk("rel_codes", 32'(codes_out), 32'(e.c));
        if (k == EV_DONE) begin
            chk("done_clk_ok", 32'(clk_ok), 32'd1);
            chk("done_ready", 32'(rif.req_ready), 32'd1);
        end
        if (k == EV_FSET) chk("fail_ready", 32'(rif.req_ready), 32'd1);
    endtask

    logic       p_prst = 1'b1;
    logic       p_ckok = 1'b0;
    logic       p_fail = 1'b0;
    pll_codes_t p_codes = DEF_C;

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (pll_reset && p_prst)
                chk("codes_stable", 32'(codes_out), 32'(p_codes));
            if (pll_reset)
                chk("clk_ok_in_rst", 32'(clk_ok), 32'd0);
            if (pll_reset && !p_prst) got(EV_PUP);
            if (!pll_reset && p_prst) got(EV_REL);
            if (!clk_ok && p_ckok)    got(EV_CKDN);
            if (done)                 got(EV_DONE);
            if (lock_lost)            got(EV_LOST);
            if (fail && !p_fail)      got(EV_FSET);
            if (!fail && p_fail)      got(EV_FCLR);
        end
        p_prst  = pll_reset;
        p_ckok  = clk_ok;
        p_fail  = fail;
        p_codes = codes_out;
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go_to(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_empty(int lim);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("pending_events", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    function automatic pll_codes_t rand_codes();
        pll_codes_t c;
        c.mdsel  = 7'($urandom_range(0, 127));
        c.odsel0 = 7'($urandom_range(0, 127));
        c.odsel1 = 7'($urandom_range(0, 127));
        c.odsel2 = 7'($urandom_range(0, 127));
        return c;
    endfunction

    task automatic drive_codes(pll_codes_t c);
        rif.req_mdsel  = c.mdsel;
        rif.req_odsel0 = c.odsel0;
        rif.req_odsel1 = c.odsel1;
        rif.req_odsel2 = c.odsel2;
    endtask

    // Valid for one edge; the accept edge is the next posedge.
    task automatic send_req(pll_codes_t c);
        drive_codes(c);
        rif.req_valid = 1'b1;
        @(negedge clk);
        rif.req_valid = 1'b0;
    endtask

    // Lock rising before edge t+1 is seen after SYNC edges, then needs
    // STB consecutive high samples.
    task automatic lock_at(int t);
        go_to(t);
        pll_lock = 1'b1;
        push(EV_DONE, cyc + SYNC + STB);
    endtask

    // Lock drop lands on the same edge as the accept: no lock_lost.
    task automatic reconfig(pll_codes_t c, output int rel);
        int t = cyc;
        pll_lock = 1'b0;
        step(SYNC);
        push(EV_PUP,  t + SYNC + 1);
        push(EV_CKDN, t + SYNC + 1);
        push(EV_REL,  t + SYNC + 1 + RSTC, c);
        send_req(c);
        rel = t + SYNC + 1 + RSTC;
    endtask

    task automatic lock_loss(int d);
        int t = cyc;
        pll_lock = 1'b0;
        push(EV_CKDN, t + SYNC + 1);
        push(EV_LOST, t + SYNC + 1);
        step(d);
        pll_lock = 1'b1;
        push(EV_DONE, cyc + SYNC + STB);
    endtask

    // h high cycles (< STB) then low: must not complete qualification.
    task automatic glitch_lock(int t0, int h);
        go_to(t0);
        pll_lock = 1'b1;
        step(h);
        pll_lock = 1'b0;
        step($urandom_range(1, 6));
        pll_lock = 1'b1;
        push(EV_DONE, cyc + SYNC + STB);
    endtask

    task automatic timeout_run();
        pll_codes_t c  = rand_codes();
        pll_codes_t c2 = rand_codes();
        int n = cyc + 1;
        int f;
        pll_lock = 1'b0;
        push(EV_PUP,  n);
        push(EV_CKDN, n);
        for (int i = 0; i <= MRT; i++) begin
            if (i > 0) push(EV_PUP, n + i * (RSTC + TMO));
            push(EV_REL, n + i * (RSTC + TMO) + RSTC, c);
        end
        push(EV_FSET, n + MRT * (RSTC + TMO) + RSTC + TMO);
        send_req(c);
        go_to(n + 10);
        chk("wait_not_ready", 32'(rif.req_ready), 32'd0);
        drive_codes(rand_codes());
        rif.req_valid = 1'b1;
        step(5);
        rif.req_valid = 1'b0;
        wait_empty(400);
        chk("fail_sticky", 32'(fail), 32'd1);
        chk("fail_clk_ok", 32'(clk_ok), 32'd0);
        f = cyc + 1;
        push(EV_PUP,  f);
        push(EV_FCLR, f);
        push(EV_REL,  f + RSTC, c2);
        send_req(c2);
        glitch_lock(f + RSTC + 2, 5);
        wait_empty(200);
    endtask

    task automatic reset_mid();
        int t = cyc;
        int rel;
        pll_lock = 1'b0;
        push(EV_PUP,  t + 1);
        push(EV_CKDN, t + 1);
        send_req(rand_codes());
        step(1);
        reset = 1'b1;
        step(1);
        chk("midrst_codes", 32'(codes_out), 32'(DEF_C));
        chk("midrst_pll_reset", 32'(pll_reset), 32'd1);
        chk("midrst_ready", 32'(rif.req_ready), 32'd0);
        rel = cyc + RSTC;
        push(EV_REL, rel, DEF_C);
        reset = 1'b0;
        go_to(rel + 1);
        chk("wait_ready_low", 32'(rif.req_ready), 32'd0);
        drive_codes(rand_codes());
        rif.req_valid = 1'b1;
        step(3);
        rif.req_valid = 1'b0;
        lock_at(rel + 6);
        wait_empty(200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rel;
        rif.req_valid = 1'b0;
        drive_codes('0);
        reset    = 1'b1;
        pll_lock = 1'b0;
        step(3);
        chk("rst_pll_reset", 32'(pll_reset), 32'd1);
        chk("rst_codes", 32'(codes_out), 32'(DEF_C));
        chk("rst_clk_ok", 32'(clk_ok), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lock_lost", 32'(lock_lost), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_ready", 32'(rif.req_ready), 32'd0);

        rel = cyc + RSTC;
        push(EV_REL, rel, DEF_C);
        reset = 1'b0;
        lock_at(rel + 5);
        wait_empty(200);
        chk("run_clk_ok", 32'(clk_ok), 32'd1);

        reconfig(PAL_CODES, rel);
        lock_at(rel + $urandom_range(1, 20));
        wait_empty(200);

        lock_loss(5);
        wait_empty(200);

        timeout_run();
        reset_mid();

        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 2))
                0: begin
                    reconfig(rand_codes(), rel);
                    lock_at(rel + $urandom_range(1, 20));
                end
                1: lock_loss($urandom_range(1, 12));
                default: begin
                    reconfig(rand_codes(), rel);
                    glitch_lock(rel + $urandom_range(1, 10),
                                $urandom_range(1, STB - 1));
                end
            endcase
            wait_empty(200);
        end

        step(30);
        chk("end_clk_ok", 32'(clk_ok), 32'd1);
        chk("end_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
